// File: rtl/alu_flag_stage.sv
// alu_flag_stage: registered result/flag stage behind the 16-bit CLA adder.
// Derives Z/N/C/V from the adder result and buffers result+flags in a
// 2-entry skid FIFO with a valid/ready handshake on both sides.
// Optional feature macro: ALU_FLAG_STICKY_EN (sticky overflow flag).
module alu_flag_stage #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_r,
   input  logic             in_co,
   input  logic             in_a_msb,
   input  logic             in_b_msb,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_r,
   output logic             out_z,
   output logic             out_n,
   output logic             out_c,
   output logic             out_v,
   input  logic             sticky_clr,
   output logic             sticky_v
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } cnt_t;

   cnt_t             count_q;
   cnt_t             count_d;
   logic             wr_ptr;
   logic             rd_ptr;
   logic [WIDTH-1:0] mem_r [2];
   logic [3:0]       mem_f [2];   // {z, n, c, v}
   logic             push;
   logic             pop;
   logic             z_in;
   logic             n_in;
   logic             v_in;

   // Flags are derived at input time so the stored entry is self-contained.
   // V uses the un-inverted b sign: add overflows when signs agree, subtract
   // when they differ, and in both cases the result sign departs from a.
   assign z_in = (in_r == '0);
   assign n_in = in_r[WIDTH-1];
   assign v_in = ((in_a_msb ^ in_b_msb) == in_sub) & (in_r[WIDTH-1] ^ in_a_msb);

   // in_ready depends on registered count only; no path from out_ready.
   assign in_ready  = (2'(count_q) != 2'(DEPTH));
   assign out_valid = (count_q != EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign out_r = mem_r[rd_ptr];
   assign out_z = mem_f[rd_ptr][3];
   assign out_n = mem_f[rd_ptr][2];
   assign out_c = mem_f[rd_ptr][1];
   assign out_v = mem_f[rd_ptr][0];

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= EMPTY;
      end else begin
         count_q <= count_d;
      end
   end

   // Occupancy next-state from push/pop.
   always_comb begin
      count_d = count_q;
      unique case (count_q)
         EMPTY: if (push) count_d = ONE;
         ONE: begin
            if (push && !pop)      count_d = FULL;
            else if (pop && !push) count_d = EMPTY;
         end
         FULL: if (pop) count_d = ONE;
         default: count_d = EMPTY;
      endcase
   end

   // Pointers and storage; entries are cleared so reset shows zero outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         mem_r[0] <= '0;
         mem_r[1] <= '0;
         mem_f[0] <= '0;
         mem_f[1] <= '0;
      end else begin
         if (push) begin
            mem_r[wr_ptr] <= in_r;
            mem_f[wr_ptr] <= {z_in, n_in, in_co, v_in};
            wr_ptr        <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

`ifdef ALU_FLAG_STICKY_EN
   logic sticky_q;

   // Sticky overflow: set by any V=1 push, which takes priority over clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
      end else if (push && v_in) begin
         sticky_q <= 1'b1;
      end else if (sticky_clr) begin
         sticky_q <= 1'b0;
      end
   end

   assign sticky_v = sticky_q;
`else
   logic unused_sticky_clr;

   assign unused_sticky_clr = sticky_clr;
   assign sticky_v          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_flag_stage.sv
// tb_alu_flag_stage: directed scoreboard bench for alu_flag_stage.
// Expected result/flags come from an independent arithmetic model of the
// adder and are queued at push time, then compared whenever the head is valid.
module tb_alu_flag_stage;

   typedef struct packed {
      logic [15:0] r;
      logic        z;
      logic        n;
      logic        c;
      logic        v;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_r;
   logic        in_co;
   logic        in_a_msb;
   logic        in_b_msb;
   logic        in_sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_r;
   logic        out_z;
   logic        out_n;
   logic        out_c;
   logic        out_v;
   logic        sticky_clr;
   logic        sticky_v;

   entry_t      sb[$];
   logic        exp_sticky;
   int          vectors = 0;
   int          miscompares = 0;

   alu_flag_stage #(.WIDTH(16), .DEPTH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_r       (in_r),
      .in_co      (in_co),
      .in_a_msb   (in_a_msb),
      .in_b_msb   (in_b_msb),
      .in_sub     (in_sub),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_r      (out_r),
      .out_z      (out_z),
      .out_n      (out_n),
      .out_c      (out_c),
      .out_v      (out_v),
      .sticky_clr (sticky_clr),
      .sticky_v   (sticky_v)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, update
   // the model with this cycle's push/pop, then advance to the next negedge.
   task automatic cyc(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic rdy, input logic clr);
      logic [16:0] sum;
      int          res;
      entry_t      e;
      logic        exp_push;
      logic        exp_pop;
      sum = {1'b0, a} + (s ? ({1'b0, ~b} + 17'd1) : {1'b0, b});
      res = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
      e.r = sum[15:0];
      e.c = sum[16];
      e.z = (sum[15:0] == 16'h0000);
      e.n = sum[15];
      e.v = (res > 32767) || (res < -32768);
      in_valid   = v;
      in_r       = sum[15:0];
      in_co      = sum[16];
      in_a_msb   = a[15];
      in_b_msb   = b[15];
      in_sub     = s;
      out_ready  = rdy;
      sticky_clr = clr;
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, (sb.size() != 2)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
      chk("sticky_v", {31'd0, sticky_v}, {31'd0, exp_sticky});
      if (sb.size() != 0) begin
         chk("head_r", {16'd0, out_r}, {16'd0, sb[0].r});
         chk("head_zncv", {28'd0, out_z, out_n, out_c, out_v},
             {28'd0, sb[0].z, sb[0].n, sb[0].c, sb[0].v});
      end
      exp_pop  = (sb.size() != 0) && rdy;
      exp_push = v && (sb.size() != 2);
      if (exp_pop) void'(sb.pop_front());
      if (exp_push) sb.push_back(e);
`ifdef ALU_FLAG_STICKY_EN
      if (exp_push && e.v) exp_sticky = 1'b1;
      else if (clr)        exp_sticky = 1'b0;
`endif
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_reset_state();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_r", {16'd0, out_r}, 32'd0);
      chk("rst_flags", {28'd0, out_z, out_n, out_c, out_v}, 32'd0);
      chk("rst_sticky", {31'd0, sticky_v}, 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_r       = '0;
      in_co      = 1'b0;
      in_a_msb   = 1'b0;
      in_b_msb   = 1'b0;
      in_sub     = 1'b0;
      out_ready  = 1'b0;
      sticky_clr = 1'b0;
      exp_sticky = 1'b0;
      #1;
      chk_reset_state();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Adds and subtracts back to back with out_ready=1 (no bubbles)
      cyc(1'b1, 16'h60E0, 16'h36B6, 1'b0, 1'b1, 1'b0);
      chk("t1_r", {16'd0, out_r}, 32'h9796);
      chk("t1_zncv", {28'd0, out_z, out_n, out_c, out_v}, 32'b0101);
      cyc(1'b1, 16'h0EB4, 16'hF2E1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 16'h7F01, 16'h2552, 1'b0, 1'b1, 1'b0);
      chk("t3_r", {16'd0, out_r}, 32'hA453);
      cyc(1'b1, 16'h0000, 16'hB6B6, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
      chk("t5_zncv", {28'd0, out_z, out_n, out_c, out_v}, 32'b1010);
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

      // Backpressure: third entry held off while FULL, then drained in order
      cyc(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

      // count=1 with simultaneous push and pop, then hold
      cyc(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

      // Sticky overflow: set, hold through V=0, clear, clear+set together
      cyc(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

      // Random traffic with random backpressure
      for (int i = 0; i < 40; i++) begin
         cyc(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0));
      end

      // Fill, then assert reset mid-cycle while FULL
      cyc(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h7000, 16'h7000, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h7000, 16'h7000, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk_reset_state();
      sb.delete();
      exp_sticky = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // First push after reset is accepted on the first edge
      cyc(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 16'h0F0F, 16'hF0F1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_flag_stage.md
# alu_flag_stage

Registered result/flag stage directly downstream of the 16-bit carry-lookahead adder/subtractor. It captures the adder's sum and carry-out together with the operand sign bits and the `sub` control. It derives Z/N/C/V flags and buffers the results in a 2-entry skid FIFO. Results go to the writeback/branch logic through a valid/ready handshake, so adder timing is decoupled from downstream stalls.

## Interface
Parameters:
- `WIDTH`, 16, datapath width. Must match the adder width; only 16 is verified.
- `DEPTH`, 2, skid FIFO entries. Fixed at 2; other values are unsupported.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  adder result presented this cycle.
- `in_ready`  output  1  stage can accept; equals (count != 2).
- `in_r`  input  WIDTH  adder result `r`.
- `in_co`  input  1  adder carry-out `co`.
- `in_a_msb`  input  1  bit WIDTH-1 of operand `a`.
- `in_b_msb`  input  1  bit WIDTH-1 of operand `b`, before any inversion for subtract.
- `in_sub`  input  1  operation was a subtract.
- `out_valid`  output  1  head entry valid.
- `out_ready`  input  1  consumer accepts the head entry.
- `out_r`  output  WIDTH  head result.
- `out_z`, `out_n`, `out_c`, `out_v`  output  1 each  head-entry flags.
- `sticky_clr`  input  1  clears the sticky overflow flag.
- `sticky_v`  output  1  sticky overflow flag.

## Operation
- Push occurs when `in_valid & in_ready`. Pop occurs when `out_valid & out_ready`.
- Flags are computed combinationally at input time and stored with the result:
  - Z = (in_r == 0)
  - N = in_r[WIDTH-1]
  - C = in_co. This is the raw carry-out; for subtract, C=1 means no borrow.
  - V for add = (a_msb == b_msb) & (r_msb != a_msb)
  - V for subtract = (a_msb != b_msb) & (r_msb != a_msb)
- Storage is 2 entries with a read pointer, a write pointer (each 1 bit, wrapping 1→0) and a 2-bit `count` (0..2).
- Count states:
  - EMPTY (count 0): push → ONE.
  - ONE (count 1): push only → FULL; pop only → EMPTY; push and pop together → stays ONE, and the new entry becomes head on the next cycle.
  - FULL (count 2): `in_ready`=0, so push is impossible; pop → ONE.
- A pop when empty is impossible because `out_valid`=0.
- Outputs always show the entry at the read pointer. While `out_valid & ~out_ready`, `out_r` and all flags hold stable.
- `in_valid` asserted while `in_ready`=0 is ignored. No data is lost, because upstream must hold its values.

## Timing
- Latency: an entry pushed at edge k is visible on `out_*` with `out_valid`=1 immediately after edge k, i.e. one cycle from input to output.
- Throughput: 1 entry/cycle when `out_ready` is held at 1.
- `in_ready` is a function of registered `count` only, with no combinational path from `out_ready`.
- Reset, asserted at any time including mid-stream:
  - count=0, both pointers=0.
  - `out_valid`=0, `out_r`=0, all flags 0, `sticky_v`=0.
  - `in_ready`=1 while in reset.
  - Buffered entries are discarded.
- The first push is accepted on the first rising edge after `rst_n` deasserts.

## Configuration
- `ALU_FLAG_STICKY_EN` defined:
  - `sticky_v` sets on any push whose V=1 and stays set until `sticky_clr`=1.
  - A clear and a V=1 push in the same cycle leave `sticky_v`=1 (set wins).
- Not defined: the sticky register is not built, `sticky_v` is tied to 0, and `sticky_clr` is ignored.

## Test plan
- Add 0x60E0+0x36B6, `out_ready`=1 → next cycle `out_r`=0x9796, N=1, V=1, C=0, Z=0.
- Add 0x0EB4+0xF2E1 → `out_r`=0x0195, C=1, V=0, N=0. Then add 0x7F01+0x2552 on the next cycle → `out_r`=0xA453, V=1, N=1. Check back-to-back throughput with no bubble.
- Subtract 0x0000−0xB6B6 (`in_r`=0x494A, co=0) → C=0, V=0, N=0. Subtract 0x0000−0x0000 (`in_r`=0, co=1) → Z=1, C=1.
- Hold `out_ready`=0 and push 3 entries → `in_ready` drops after the 2nd, the 3rd is held off, and outputs stay on the 1st. Release `out_ready` → entries drain in order and the 3rd is accepted.
- With count=1, push and pop in the same cycle → count stays 1 and the new entry is at the head. Assert `rst_n`=0 with FULL → `out_valid`=0 and `in_ready`=1 immediately.
- With `ALU_FLAG_STICKY_EN`: push a V=1 result, then V=0 results → `sticky_v` stays 1. Assert `sticky_clr` → 0. Clear plus a V=1 push in the same cycle → 1. Without the macro, `sticky_v` is always 0.
